// File: rtl/ascii_text_display.sv
// rtl/ascii_text_display.sv - character buffer scanned out to a VGA DAC through an external 8x8 font ROM
module ascii_text_display #(
    parameter int COLS   = 80,
    parameter int ROWS   = 60,
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ascii_write_en,
    input  logic [12:0] ascii_write_address,
    input  logic [31:0] ascii_input,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_row,
    output logic        vga_clk,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vga_sync_n,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b
);
    localparam int DEPTH = COLS * ROWS;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [9:0]  H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]  H_VIS_C  = 10'(H_VIS);
    localparam logic [9:0]  V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0]  HS_START = 10'(H_VIS + H_FP);
    localparam logic [9:0]  HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]  VS_START = 10'(V_VIS + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [12:0] DEPTH_A  = 13'(DEPTH);
    localparam logic [12:0] COLS_A   = 13'(COLS);

    logic          pix_en;
    logic [9:0]    h_cnt;
    logic [9:0]    v_cnt;

    // Stage 0: raw timing decode of the counters; syncs are kept active-high internally
    logic          visible;
    logic          hs_act;
    logic          vs_act;
    logic [12:0]   cell_row;
    logic [12:0]   cell_col;
    logic [AW-1:0] rd_idx;

    logic [31:0]   mem [0:DEPTH-1];

    // Stage 1
    logic [31:0]   rd_word;
    logic [2:0]    h_d1;
    logic [2:0]    v_d1;
    logic          vis_d1;
    logic          hs_d1;
    logic          vs_d1;

    // Stage 2
    logic [23:0]   colour_d2;
    logic [2:0]    h_d2;
    logic          vis_d2;
    logic          hs_d2;
    logic          vs_d2;

    logic [23:0]   rgb;

    assign vga_clk    = pix_en;
    assign vga_sync_n = 1'b0;
    assign {vga_r, vga_g, vga_b} = rgb;

    assign visible  = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
    assign hs_act   = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign vs_act   = (v_cnt >= VS_START) && (v_cnt < VS_END);
    assign cell_row = {6'd0, v_cnt[9:3]};
    assign cell_col = {6'd0, h_cnt[9:3]};
    assign rd_idx   = visible ? AW'(cell_row * COLS_A + cell_col) : '0;

    // Pixel tick: half the system clock
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_en <= 1'b0;
        end else begin
            pix_en <= ~pix_en;
        end
    end

    // Raster counters: h wraps every line, v steps on each h wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Renderer write port, full clock rate; addresses past the buffer are dropped
    always_ff @(posedge clk) begin
        if (ascii_write_en && (ascii_write_address < DEPTH_A)) begin
            mem[AW'(ascii_write_address)] <= ascii_input;
        end
    end

    // S1: buffer read (sees the pre-write word on a same-cycle collision) plus delay line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_word <= '0;
            h_d1    <= '0;
            v_d1    <= '0;
            vis_d1  <= 1'b0;
            hs_d1   <= 1'b0;
            vs_d1   <= 1'b0;
        end else if (pix_en) begin
            rd_word <= mem[rd_idx];
            h_d1    <= h_cnt[2:0];
            v_d1    <= v_cnt[2:0];
            vis_d1  <= visible;
            hs_d1   <= hs_act;
            vs_d1   <= vs_act;
        end
    end

    // S2: issue the glyph row lookup and carry the colour alongside it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            font_addr <= '0;
            colour_d2 <= '0;
            h_d2      <= '0;
            vis_d2    <= 1'b0;
            hs_d2     <= 1'b0;
            vs_d2     <= 1'b0;
        end else if (pix_en) begin
            font_addr <= {rd_word[31:24], v_d1};
            colour_d2 <= rd_word[23:0];
            h_d2      <= h_d1;
            vis_d2    <= vis_d1;
            hs_d2     <= hs_d1;
            vs_d2     <= vs_d1;
        end
    end

    // S3: pick the glyph bit (bit 7 leftmost) and register the DAC outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            rgb         <= '0;
        end else if (pix_en) begin
            vga_hs      <= ~hs_d2;
            vga_vs      <= ~vs_d2;
            vga_blank_n <= vis_d2;
            rgb         <= (vis_d2 && font_row[3'd7 - h_d2]) ? colour_d2 : 24'd0;
        end
    end

endmodule

// File: tb/tb_ascii_text_display.sv
// tb/tb_ascii_text_display.sv - randomized model-checked bench for ascii_text_display
module tb_ascii_text_display;
    localparam int COLS = 8, ROWS = 5;
    localparam int H_VIS = 64, H_FP = 4, H_SYNC = 8, H_BP = 4;
    localparam int V_VIS = 40, V_FP = 2, V_SYNC = 2, V_BP = 3;
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FRAME = H_TOT * V_TOT;
    localparam int DEPTH = COLS * ROWS;
    localparam int COLL_CELL = 2 * COLS + 5;
    localparam int COLL_P = FRAME + 16 * H_TOT + 40;
    localparam int COLL_N = 2 * (COLL_P + 1) - 1;
    localparam int RAND_START = 2 * 3 * FRAME;
    localparam int KR = 5 * FRAME + 20 * H_TOT + 33;

    logic        clk = 1'b0;
    logic        rst;
    logic        ascii_write_en;
    logic [12:0] ascii_write_address;
    logic [31:0] ascii_input;
    logic [10:0] font_addr;
    logic [7:0]  font_row = 8'h00;
    logic        vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n;
    logic [7:0]  vga_r, vga_g, vga_b;

    ascii_text_display #(
        .COLS(COLS), .ROWS(ROWS),
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clk(clk), .rst(rst),
        .ascii_write_en(ascii_write_en), .ascii_write_address(ascii_write_address),
        .ascii_input(ascii_input), .font_addr(font_addr), .font_row(font_row),
        .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] font_fn(input logic [7:0] c, input int r);
        case (c)
            8'h41:   return 8'b1000_0001;
            8'h2A:   return 8'hFF;
            default: return 8'(int'(c) * 29 + r * 71) ^ 8'h5A;
        endcase
    endfunction

    // External font ROM: one clk of latency, well inside a pixel tick
    always @(posedge clk) font_row <= font_fn(font_addr[10:3], int'(font_addr[2:0]));

    // Reference model: shadow buffer plus a 3-tick queue of scanned cell words
    typedef struct {
        int          p;
        logic [31:0] word;
    } ent_t;

    logic [31:0] shadow [0:DEPTH-1];
    ent_t        pq[$];
    logic        m_phase = 1'b0;
    int          m_ticks = 0;

    function automatic int cell_of(input int p);
        int h, v;
        h = p % H_TOT;
        v = p / H_TOT;
        if (h < H_VIS && v < V_VIS) return (v / 8) * COLS + h / 8;
        return 0;
    endfunction

    always @(posedge clk) begin : model_blk
        ent_t e;
        if (!rst) begin
            m_phase = 1'b0;
            m_ticks = 0;
            pq.delete();
        end else begin
            if (m_phase) begin
                e.p = m_ticks % FRAME;
                e.word = shadow[cell_of(e.p)];
                if (pq.size() == 3) void'(pq.pop_front());
                pq.push_back(e);
                m_ticks++;
            end
            m_phase = !m_phase;
        end
        if (ascii_write_en && int'(ascii_write_address) < DEPTH)
            shadow[int'(ascii_write_address)] = ascii_input;
    end

    // Captures used by the hand-computed checks
    int          epoch = 0;
    int          n_cmp = 0;
    logic [23:0] cap [int];
    int          first_blank_n = -1;
    int          blank_cnt = 0;
    int          first_hs_n [0:1] = '{-1, -1};
    int          hs_fall[$], hs_rise[$], vs_fall[$], vs_rise[$];
    logic        prev_hs = 1'b1, prev_vs = 1'b1;

    always @(negedge clk) begin : cmp_blk
        int p, h, v;
        logic vis, ehs, evs;
        logic [7:0] fb;
        logic [23:0] er;
        if (!rst) begin
            n_cmp = 0;
            prev_hs = 1'b1;
            prev_vs = 1'b1;
            chk("rst_hs", vga_hs, 1);
            chk("rst_vs", vga_vs, 1);
            chk("rst_blank", vga_blank_n, 0);
            chk("rst_rgb", {vga_r, vga_g, vga_b}, 0);
            chk("rst_font_addr", font_addr, 0);
        end else begin
            n_cmp++;
            chk("vga_clk", vga_clk, m_phase);
            chk("sync_n", vga_sync_n, 0);
            if (pq.size() == 3) begin
                p = pq[0].p;
                h = p % H_TOT;
                v = p / H_TOT;
                vis = (h < H_VIS) && (v < V_VIS);
                ehs = !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC);
                evs = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC);
                fb = font_fn(pq[0].word[31:24], v % 8);
                er = (vis && fb[7 - (h % 8)]) ? pq[0].word[23:0] : 24'd0;
            end else begin
                vis = 1'b0;
                ehs = 1'b1;
                evs = 1'b1;
                er = 24'd0;
            end
            chk("hs", vga_hs, ehs);
            chk("vs", vga_vs, evs);
            chk("blank_n", vga_blank_n, vis);
            chk("rgb", {vga_r, vga_g, vga_b}, er);
            if (epoch == 0) begin
                if (n_cmp % 2 == 0 && n_cmp / 2 >= 3) cap[n_cmp / 2 - 3] = {vga_r, vga_g, vga_b};
                if (vga_blank_n && first_blank_n < 0) first_blank_n = n_cmp;
                if (vga_blank_n && n_cmp < 2 * (FRAME + 3)) blank_cnt++;
                if (prev_hs && !vga_hs) hs_fall.push_back(n_cmp);
                if (!prev_hs && vga_hs) hs_rise.push_back(n_cmp);
                if (prev_vs && !vga_vs) vs_fall.push_back(n_cmp);
                if (!prev_vs && vga_vs) vs_rise.push_back(n_cmp);
            end
            if (!vga_hs && first_hs_n[epoch] < 0) first_hs_n[epoch] = n_cmp;
            prev_hs = vga_hs;
            prev_vs = vga_vs;
        end
    end

    function automatic logic [23:0] capv(input int k);
        if (cap.exists(k)) return cap[k];
        return 24'hxxxxxx;
    endfunction

    function automatic int qget(input int q[$], input int i);
        if (q.size() > i) return q[i];
        return -1;
    endfunction

    task automatic do_write(input int addr, input logic [31:0] data);
        ascii_write_en = 1'b1;
        ascii_write_address = 13'(addr);
        ascii_input = data;
    endtask

    task automatic stim(input int mn);
        int sel;
        ascii_write_en = 1'b0;
        if (epoch == 0 && mn == COLL_N) begin
            do_write(COLL_CELL, {8'h2A, 24'h123456});
        end else if ((epoch == 1 || mn > RAND_START) && $urandom_range(0, 15) == 0) begin
            sel = int'($urandom_range(0, 7));
            case (sel)
                0:       do_write(DEPTH, $urandom);
                1:       do_write(4800, $urandom);
                2:       do_write(8191, $urandom);
                3:       do_write(int'($urandom_range(DEPTH, 8191)), $urandom);
                default: do_write(int'($urandom_range(0, DEPTH - 1)),
                                  {8'(8'h20 + $urandom_range(0, 94)), 24'($urandom)});
            endcase
        end
    endtask

    initial begin
        int mn;
        rst = 1'b1;
        ascii_write_en = 1'b0;
        ascii_write_address = '0;
        ascii_input = '0;
        #1 rst = 1'b0;
        #2;
        chk("init_hs", vga_hs, 1);
        chk("init_vs", vga_vs, 1);
        chk("init_blank", vga_blank_n, 0);
        chk("init_rgb", {vga_r, vga_g, vga_b}, 0);
        chk("init_font_addr", font_addr, 0);
        chk("init_vga_clk", vga_clk, 0);

        // Buffer is loaded while reset is held; the write port ignores reset
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            if (i == 0) do_write(i, {8'h41, 24'hFF0000});
            else if (i == DEPTH - 1) do_write(i, {8'h2A, 24'h00FF00});
            else if (i == COLL_CELL) do_write(i, {8'h41, 24'h0000FF});
            else do_write(i, {8'(8'h20 + $urandom_range(0, 94)), 24'($urandom)});
        end
        @(negedge clk);
        ascii_write_en = 1'b0;
        #2 rst = 1'b1;

        mn = 0;
        while (mn < 2 * KR) begin
            @(negedge clk);
            mn++;
            stim(mn);
        end
        ascii_write_en = 1'b0;
        chk("pre_rst_blank", vga_blank_n, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_hs", vga_hs, 1);
        chk("mid_rst_vs", vga_vs, 1);
        chk("mid_rst_blank", vga_blank_n, 0);
        chk("mid_rst_rgb", {vga_r, vga_g, vga_b}, 0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        epoch = 1;
        for (mn = 1; mn <= 4 * FRAME; mn++) begin
            @(negedge clk);
            stim(mn);
        end
        @(negedge clk);
        ascii_write_en = 1'b0;

        chk("first_blank_n", first_blank_n, 6);
        chk("frame0_blank_count", blank_cnt, 5120);
        chk("glyph_px0", capv(0), 24'hFF0000);
        for (int x = 1; x <= 6; x++) chk("glyph_px_mid", capv(x), 24'h000000);
        chk("glyph_px7", capv(7), 24'hFF0000);
        for (int y = 32; y < 40; y++)
            for (int x = 56; x < 64; x++)
                chk("last_cell", capv(y * H_TOT + x), 24'h00FF00);
        chk("coll_same_scan_old", capv(COLL_P), 24'h0000FF);
        chk("coll_next_tick_new", capv(COLL_P + 1), 24'h123456);
        chk("coll_next_line_new", capv(COLL_P + H_TOT + 1), 24'h123456);
        chk("coll_next_frame_new", capv(COLL_P + FRAME), 24'h123456);
        chk("hs_period", qget(hs_fall, 1) - qget(hs_fall, 0), 160);
        chk("hs_low_width", qget(hs_rise, 0) - qget(hs_fall, 0), 16);
        chk("hs_first_fall", qget(hs_fall, 0), 142);
        chk("vs_period", qget(vs_fall, 1) - qget(vs_fall, 0), 7520);
        chk("vs_low_width", qget(vs_rise, 0) - qget(vs_fall, 0), 320);
        chk("vs_first_fall", qget(vs_fall, 0), 6726);
        chk("hs_first_fall_after_rst", first_hs_n[1], 142);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
